// File: rtl/bus_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_mailbox_pkg
// Purpose  : Shared register offsets, STATUS field positions and bus FSM
//            states for the bus mailbox.
// Revision : 1.0 - initial release
// ============================================================================
package bus_mailbox_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int STATUS_TX_FULL  = 16;
    localparam int STATUS_RX_EMPTY = 17;
    localparam int STATUS_OVF      = 18;
    localparam int STATUS_UNF      = 19;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mailbox_fifo
// Purpose  : Synchronous DEPTH x 32 FIFO with flush and a combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module mailbox_fifo #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Full/empty come from the registered count, so a push into a full FIFO
    // is refused even when a pop happens in the same cycle.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : bus_mailbox
// Purpose  : SoC bus responder exposing a TX/RX word mailbox to a stream agent.
// Revision : 1.0 - initial release
// ============================================================================
module bus_mailbox
    import bus_mailbox_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic [31:0] o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_rx_irq
);

    bus_state_t    r_state;
    logic          r_ready;
    logic [31:0]   r_rdata;
    logic          r_ovf;
    logic          r_unf;

    logic [31:0]   w_rx_head;
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;

    logic          w_accept;
    logic [1:0]    w_sel;
    logic [31:0]   w_status;
    logic [31:0]   w_read_value;
    logic          w_tx_push;
    logic          w_rx_pop;
    logic          w_tx_flush;
    logic          w_rx_flush;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          w_ovf_clr;
    logic          w_unf_clr;
    logic          w_unused_addr;

    assign w_sel         = i_address[3:2];
    assign w_unused_addr = ^{i_address[31:4], i_address[1:0]};

    // The register action fires only on the IDLE cycle, so a held request
    // never repeats its side effect.
    assign w_accept = (r_state == IDLE) && i_request;

    always_comb begin
        w_status                  = '0;
        w_status[7:0]             = 8'(w_tx_count);
        w_status[15:8]            = 8'(w_rx_count);
        w_status[STATUS_TX_FULL]  = w_tx_full;
        w_status[STATUS_RX_EMPTY] = w_rx_empty;
        w_status[STATUS_OVF]      = r_ovf;
        w_status[STATUS_UNF]      = r_unf;
    end

    always_comb begin
        w_tx_push    = 1'b0;
        w_rx_pop     = 1'b0;
        w_tx_flush   = 1'b0;
        w_rx_flush   = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        w_ovf_clr    = 1'b0;
        w_unf_clr    = 1'b0;
        w_read_value = '0;
        if (w_accept) begin
            case (w_sel)
                REG_TXDATA: begin
                    if (i_rw) begin
                        w_tx_push = 1'b1;
                        w_ovf_set = w_tx_full;
                    end
                end
                REG_RXDATA: begin
                    if (!i_rw) begin
                        w_rx_pop     = 1'b1;
                        w_unf_set    = w_rx_empty;
                        w_read_value = w_rx_empty ? 32'd0 : w_rx_head;
                    end
                end
                REG_STATUS: begin
                    if (i_rw) begin
                        w_ovf_clr = i_wdata[STATUS_OVF];
                        w_unf_clr = i_wdata[STATUS_UNF];
                    end else begin
                        w_read_value = w_status;
                    end
                end
                REG_CONTROL: begin
                    if (i_rw) begin
                        w_tx_flush = i_wdata[0];
                        w_rx_flush = i_wdata[1];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_request) begin
                        r_state <= ACK;
                        r_ready <= 1'b1;
                        r_rdata <= w_read_value;
                    end
                end
                ACK: begin
                    if (!i_request) begin
                        r_state <= IDLE;
                        r_ready <= 1'b0;
                        r_rdata <= '0;
                    end
                end
            endcase
            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_clr) begin
                r_unf <= 1'b0;
            end else if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_rdata    = r_rdata;
    assign o_tx_valid = !w_tx_empty;
    assign o_rx_ready = !w_rx_full;
    assign o_rx_irq   = !w_rx_empty;

    mailbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (w_tx_push),
        .i_pop     (o_tx_valid && i_tx_ready),
        .i_flush   (w_tx_flush),
        .i_wdata   (i_wdata),
        .o_rdata   (o_tx_data),
        .o_count   (w_tx_count),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty)
    );

    mailbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (i_rx_valid && o_rx_ready),
        .i_pop     (w_rx_pop),
        .i_flush   (w_rx_flush),
        .i_wdata   (i_rx_data),
        .o_rdata   (w_rx_head),
        .o_count   (w_rx_count),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mailbox
// Purpose  : Self-checking bench for bus_mailbox against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mailbox;
    import bus_mailbox_pkg::*;

    localparam int DEPTH = 16;

    logic        i_clock    = 1'b0;
    logic        i_reset_n  = 1'b0;
    logic        i_request  = 1'b0;
    logic        i_rw       = 1'b0;
    logic [31:0] i_address  = '0;
    logic [31:0] i_wdata    = '0;
    logic        i_tx_ready = 1'b0;
    logic [31:0] i_rx_data  = '0;
    logic        i_rx_valid = 1'b0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        o_rx_ready;
    logic        o_rx_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_ovf;
    bit          m_unf;
    bit          m_ready;
    logic [31:0] m_rdata;

    bus_mailbox #(.DEPTH(DEPTH)) dut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_request  (i_request),
        .i_rw       (i_rw),
        .i_address  (i_address),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_ready    (o_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_rx_irq   (o_rx_irq)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[7:0]   = 8'(m_tx.size());
        s[15:8]  = 8'(m_rx.size());
        s[16]    = (m_tx.size() == DEPTH);
        s[17]    = (m_rx.size() == 0);
        s[18]    = m_ovf;
        s[19]    = m_unf;
        return s;
    endfunction

    task automatic compare_outputs();
        check("tx_valid", o_tx_valid, m_tx.size() > 0);
        if (m_tx.size() > 0) check("tx_data", o_tx_data, m_tx[0]);
        check("rx_ready", o_rx_ready, m_rx.size() < DEPTH);
        check("rx_irq", o_rx_irq, m_rx.size() > 0);
        check("ready", o_ready, m_ready);
        check("rdata", o_rdata, m_rdata);
    endtask

    // Applies what one clock edge does, given the inputs currently driven.
    task automatic model_edge();
        bit          tx_pop  = (m_tx.size() > 0) && i_tx_ready;
        bit          rx_push = i_rx_valid && (m_rx.size() < DEPTH);
        bit          do_tx_push = 1'b0;
        bit          do_rx_pop  = 1'b0;
        bit          fl_tx = 1'b0;
        bit          fl_rx = 1'b0;
        logic [31:0] rd = '0;
        logic [31:0] status = m_status();
        if (!m_ready && i_request) begin
            case (i_address[3:2])
                REG_TXDATA:  if (i_rw) begin
                                 if (m_tx.size() == DEPTH) m_ovf = 1'b1;
                                 else do_tx_push = 1'b1;
                             end
                REG_RXDATA:  if (!i_rw) begin
                                 if (m_rx.size() == 0) m_unf = 1'b1;
                                 else begin rd = m_rx[0]; do_rx_pop = 1'b1; end
                             end
                REG_STATUS:  if (i_rw) begin
                                 if (i_wdata[18]) m_ovf = 1'b0;
                                 if (i_wdata[19]) m_unf = 1'b0;
                             end else rd = status;
                REG_CONTROL: if (i_rw) begin
                                 fl_tx = i_wdata[0];
                                 fl_rx = i_wdata[1];
                             end
            endcase
            m_ready = 1'b1;
            m_rdata = rd;
        end else if (m_ready && !i_request) begin
            m_ready = 1'b0;
            m_rdata = '0;
        end
        if (tx_pop) void'(m_tx.pop_front());
        if (do_tx_push) m_tx.push_back(i_wdata);
        if (fl_tx) m_tx.delete();
        if (do_rx_pop) void'(m_rx.pop_front());
        if (rx_push) m_rx.push_back(i_rx_data);
        if (fl_rx) m_rx.delete();
    endtask

    // Inputs are set on a falling edge; outputs are checked on the next one.
    task automatic tick();
        model_edge();
        @(posedge i_clock);
        @(negedge i_clock);
        compare_outputs();
    endtask

    task automatic reset_dut();
        i_reset_n  = 1'b0;
        i_request  = 1'b0;
        i_rw       = 1'b0;
        i_tx_ready = 1'b0;
        i_rx_valid = 1'b0;
        m_tx.delete();
        m_rx.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_ready = 1'b0;
        m_rdata = '0;
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        compare_outputs();
    endtask

    task automatic bus_op(input bit rw, input logic [1:0] sel, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic [31:0] addr = $urandom();
        addr[3:2] = sel;
        i_request = 1'b1;
        i_rw      = rw;
        i_address = addr;
        i_wdata   = wd;
        tick();
        check("bus_latency", o_ready, 1'b1);
        rd = o_rdata;
        i_request = 1'b0;
        i_rw      = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int          n;

        reset_dut();

        // Post-reset status
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("reset_status", rd, 32'h0002_0000);
        check("reset_tx_valid", o_tx_valid, 1'b0);
        check("reset_rx_ready", o_rx_ready, 1'b1);

        // Two TX pushes, then drain in order
        bus_op(1'b1, REG_TXDATA, 32'hDEAD_BEEF, rd);
        bus_op(1'b1, REG_TXDATA, 32'h1234_5678, rd);
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("tx_two_status", rd, 32'h0002_0002);
        check("tx_head_first", o_tx_data, 32'hDEAD_BEEF);
        i_tx_ready = 1'b1;
        tick();
        check("tx_head_second", o_tx_data, 32'h1234_5678);
        tick();
        check("tx_drained", o_tx_valid, 1'b0);
        i_tx_ready = 1'b0;

        // Fill TX, overflow, clear OVF, drain exactly DEPTH words
        for (int i = 0; i < DEPTH; i++) bus_op(1'b1, REG_TXDATA, 32'h100 + i, rd);
        bus_op(1'b1, REG_TXDATA, 32'hBAD0_BAD0, rd);
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("tx_full_status", rd, 32'h0007_0010);
        bus_op(1'b1, REG_STATUS, 32'h0004_0000, rd);
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("ovf_cleared", rd, 32'h0003_0010);
        i_tx_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_tx_valid) n++;
            tick();
        end
        check("tx_drain_count", n, DEPTH);
        i_tx_ready = 1'b0;

        // RX stream of three words, popped by the CPU, then underflow
        i_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_rx_data = 32'hA + i;
            tick();
        end
        i_rx_valid = 1'b0;
        check("rx_irq_set", o_rx_irq, 1'b1);
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("rx_three_status", rd, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            bus_op(1'b0, REG_RXDATA, '0, rd);
            check("rx_pop_value", rd, 32'hA + i);
        end
        bus_op(1'b0, REG_RXDATA, '0, rd);
        check("rx_empty_read", rd, 32'h0);
        check("rx_irq_clear", o_rx_irq, 1'b0);
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("unf_status", rd, 32'h000A_0000);
        bus_op(1'b1, REG_STATUS, 32'h0008_0000, rd);

        // Held request performs exactly one pop
        i_rx_valid = 1'b1;
        i_rx_data  = 32'h1111;
        tick();
        i_rx_data  = 32'h2222;
        tick();
        i_rx_valid = 1'b0;
        i_request  = 1'b1;
        i_rw       = 1'b0;
        i_address  = 32'h0000_0004;
        tick();
        check("hold_first", o_rdata, 32'h1111);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_ready", o_ready, 1'b1);
            check("hold_rdata", o_rdata, 32'h1111);
        end
        i_request = 1'b0;
        tick();
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("hold_one_pop", rd, 32'h0000_0100);
        bus_op(1'b0, REG_RXDATA, '0, rd);
        check("hold_second", rd, 32'h2222);

        // RX flush while full with the producer still valid
        i_rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            i_rx_data = 32'h5000 + i;
            tick();
        end
        check("rx_full_ready", o_rx_ready, 1'b0);
        i_request = 1'b1;
        i_rw      = 1'b1;
        i_address = 32'h0000_000C;
        i_wdata   = 32'h2;
        tick();
        check("flush_rx_ready", o_rx_ready, 1'b1);
        check("flush_rx_irq", o_rx_irq, 1'b0);
        i_rx_valid = 1'b0;
        i_request  = 1'b0;
        tick();
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("flush_status", rd, 32'h0002_0000);

        // Reset while in ACK
        bus_op(1'b1, REG_TXDATA, 32'h7777, rd);
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h0000_0008;
        tick();
        #2;
        i_reset_n = 1'b0;
        #1;
        check("reset_async_ready", o_ready, 1'b0);
        check("reset_async_tx", o_tx_valid, 1'b0);
        reset_dut();
        bus_op(1'b0, REG_STATUS, '0, rd);
        check("post_reset_status", rd, 32'h0002_0000);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int phase = cyc / 500;
            i_tx_ready = ($urandom_range(0, 5) < phase);
            i_rx_valid = ($urandom_range(0, 5) >= phase);
            i_rx_data  = $urandom();
            if (!i_request && !m_ready) begin
                if ($urandom_range(0, 2) == 0) begin
                    int          pick = $urandom_range(0, 9);
                    logic [31:0] addr = $urandom();
                    logic [1:0]  sel;
                    if (pick < 4)      sel = REG_TXDATA;
                    else if (pick < 7) sel = REG_RXDATA;
                    else if (pick < 9) sel = REG_STATUS;
                    else               sel = REG_CONTROL;
                    addr[3:2] = sel;
                    i_request = 1'b1;
                    i_rw      = (sel == REG_RXDATA) ? $urandom_range(0, 5) == 0
                                                    : $urandom_range(0, 4) != 0;
                    i_address = addr;
                    i_wdata   = $urandom();
                end
            end else if (i_request && m_ready) begin
                if ($urandom_range(0, 1) == 0) i_request = 1'b0;
            end
            tick();
        end
        i_request = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
